multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder; consumes its 4-bit ALUOperation code plus register/immediate operands.
- Logical/arithmetic ops complete in one cycle.
- SLL/SRL use an iterative 1-bit-per-cycle shifter sized for area, under a start/busy/done handshake.
- Result and Zero are registered and held until the next completion; the branch/writeback logic samples them on done.

Parameters:
- DATA_WIDTH, 32: operand/result width.
- SHAMT_WIDTH, 5: shift-amount width; max shift = 2^SHAMT_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where busy=0.
- ALUOperation  input  4  op code from ALU control.
- A  input  DATA_WIDTH  operand A (rs).
- B  input  DATA_WIDTH  operand B (rt or immediate); also the shift source.
- shamt  input  SHAMT_WIDTH  shift amount.
- ALUResult  output  DATA_WIDTH  registered result.
- Zero  output  1  registered; 1 when ALUResult==0.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when ALUResult/Zero have just been updated.

Behaviour:
- Reset: on a clk edge with reset=1:
  - ALUResult=0, Zero=1, busy=0, done=0, state=IDLE.
  - Counter and working register cleared.
  - Reset overrides start and aborts any shift in progress; no done is issued for an aborted op.
- Op codes:
  - 0000 AND: A&B.
  - 0001 OR: A|B.
  - 0010 NOR: ~(A|B).
  - 0011 ADD: A+B modulo 2^DATA_WIDTH, carry discarded.
  - 0100 SUB: A-B modulo 2^DATA_WIDTH (two's complement).
  - 0101 SLL: B<<shamt, zero fill.
  - 0110 SRL: B>>shamt, logical, zero fill.
  - Any other code (including 1001): result 0 and done still pulsed.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge k:
  - Operands, op and shamt are latched at edge k.
  - Non-shift op, or shift with shamt=0: ALUResult/Zero written at edge k; done=1 during cycle k..k+1; stay IDLE.
  - Shift with shamt=s>0: work reg=B, count=s, busy=1, go to SHIFT.
- SHIFT:
  - Each edge shifts the work reg by one bit in the latched direction and decrements count.
  - On the edge where count reaches 0: ALUResult=work reg shifted, Zero updated, busy=0, done=1 for one cycle, return to IDLE.
  - Total latency is s+1 edges from acceptance (s=31 gives 32 edges).
- Handshake:
  - start while busy=1 is ignored and has no side effects.
  - Input changes after acceptance do not affect the op in flight.
  - Back-to-back single-cycle ops are allowed every cycle: done stays high on consecutive cycles, each marking a new result.
  - A new start is accepted on the edge after the SHIFT-completion edge (busy=0 then).
- Holding: ALUResult/Zero hold their value when done=0.
- Zero is computed from the value being written, never from stale data.

Optional Feature:
- Macro MULTICYCLE_ALU_OVERFLOW_EN.
- Defined:
  - Adds output port Overflow (1 bit), registered alongside ALUResult.
  - Set on ADD when A,B have equal sign and the result sign differs.
  - Set on SUB when A,B have different sign and the result sign differs from A.
  - 0 for all other ops; reset value 0; held between completions.
- Undefined: port and logic absent; ADD/SUB wrap silently.

Test Plan:
- Reset, then start with op=0011, A=5, B=7 → next cycle ALUResult=12, Zero=0, done=1 for exactly one cycle, busy never 1.
- op=0100, A=9, B=9 → ALUResult=0, Zero=1. Then op=0010, A=0, B=0 → ALUResult=0xFFFFFFFF, Zero=0.
- op=0101, B=0x00000001, shamt=4 → busy high 4 cycles, done on 5th edge after acceptance, ALUResult=0x00000010. Also start with op=0011 pulsed during busy → ignored, result unchanged.
- op=0110, B=0x80000000, shamt=31 → ALUResult=0x00000001 after 32 edges. Also shamt=0 with op=0110, B=0xABCD → single-cycle, ALUResult=0xABCD.
- During SHIFT (op=0101, shamt=10), assert reset at the 3rd shift edge → ALUResult=0, Zero=1, busy=0, no done pulse; subsequent ADD 1+1 gives 2.
- With MULTICYCLE_ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 → ALUResult=0x80000000, Overflow=1. SUB 0x80000000-1 → Overflow=1. AND → Overflow=0. Invalid op 1001 → ALUResult=0, Zero=1, done pulsed.

Source files
------------

// File: rtl/multicycle_alu.sv
// multicycle_alu: execute-stage ALU.
// Logic and arithmetic ops finish in one cycle. SLL/SRL use a 1-bit-per-cycle
// shifter behind a start/busy/done handshake. ALUResult and Zero are registered
// and held between completions.
// Optional feature: define MULTICYCLE_ALU_OVERFLOW_EN to add a registered
// Overflow output for signed ADD/SUB.
module multicycle_alu #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero,
    output logic                   busy,
    output logic                   done
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
    ,
    output logic                   Overflow
`endif
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  work_q, work_d;
    logic [SHAMT_WIDTH-1:0] count_q, count_d;
    logic                   dir_left_q, dir_left_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ov_q, ov_d;

    logic [DATA_WIDTH-1:0]  single_result;
    logic                   single_ov;
    logic                   is_shift;
    logic [DATA_WIDTH-1:0]  shifted;

    // Single-cycle result for the current inputs; a shift only lands here when shamt is 0
    always_comb begin
        single_result = '0;
        single_ov     = 1'b0;
        is_shift      = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
        case (ALUOperation)
            OP_AND: single_result = A & B;
            OP_OR:  single_result = A | B;
            OP_NOR: single_result = ~(A | B);
            OP_ADD: begin
                single_result = A + B;
                single_ov     = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                                (single_result[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                single_result = A - B;
                single_ov     = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                                (single_result[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
            end
            OP_SLL, OP_SRL: single_result = B;
            default: single_result = '0;
        endcase
    end

    // One-bit step of the iterative shifter in the latched direction
    always_comb begin
        shifted = dir_left_q ? (work_q << 1) : (work_q >> 1);
    end

    // Next-state logic for the IDLE/SHIFT controller and the result registers
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        count_d    = count_q;
        dir_left_d = dir_left_q;
        result_d   = result_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ov_d       = ov_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        work_d     = B;
                        count_d    = shamt;
                        dir_left_d = (ALUOperation == OP_SLL);
                        busy_d     = 1'b1;
                        state_d    = SHIFT;
                    end else begin
                        result_d = single_result;
                        zero_d   = (single_result == '0);
                        ov_d     = single_ov;
                        done_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d  = shifted;
                count_d = count_q - SHAMT_WIDTH'(1);
                if (count_q == SHAMT_WIDTH'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    ov_d     = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any shift without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            count_q    <= '0;
            dir_left_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            count_q    <= count_d;
            dir_left_q <= dir_left_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ov_q       <= ov_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef MULTICYCLE_ALU_OVERFLOW_EN
    assign Overflow = ov_q;
`else
    // Overflow flop is left unobserved when the port is absent
    logic unused_ov;
    assign unused_ov = ov_q;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_multicycle_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;
    logic        done;
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
    logic        Overflow;
`endif

    int checks;
    int errors;

    multicycle_alu #(
        .DATA_WIDTH(32),
        .SHAMT_WIDTH(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ALUOperation(ALUOperation),
        .A(A),
        .B(B),
        .shamt(shamt),
        .ALUResult(ALUResult),
        .Zero(Zero),
        .busy(busy),
        .done(done)
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
        ,
        .Overflow(Overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the op-code table
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return ~(a | b);
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return b << sh;
            4'd6:    return b >> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Signed overflow: true result falls outside the 32-bit signed range
    function automatic logic ref_overflow(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd3)      r = sa + sb;
        else if (op == 4'd4) r = sa - sb;
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Edges after acceptance until done
    function automatic int ref_latency(input logic [3:0] op, input logic [4:0] sh);
        if ((op == 4'd5 || op == 4'd6) && sh != 5'd0) return int'(sh);
        return 0;
    endfunction

    // Wait (bounded) for done; returns edges waited
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Issue one op at the next edge and check latency, result, flags
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        int lat;
        int edges;
        logic [31:0] exp_r;
        lat   = ref_latency(op, sh);
        exp_r = ref_result(op, a, b, sh);
        ALUOperation = op;
        A            = a;
        B            = b;
        shamt        = sh;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (lat == 0) begin
            check({tag, ".done"}, 32'(done), 32'd1);
            check({tag, ".busy"}, 32'(busy), 32'd0);
        end else begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".done_early"}, 32'(done), 32'd0);
            // scramble inputs: op in flight must not see them
            A = $urandom;
            B = $urandom;
            shamt = 5'($urandom);
            ALUOperation = 4'($urandom);
            wait_done(edges);
            check({tag, ".latency"}, 32'(edges), 32'(lat));
            check({tag, ".busy_end"}, 32'(busy), 32'd0);
        end
        check({tag, ".result"}, ALUResult, exp_r);
        check({tag, ".zero"}, 32'(Zero), 32'(exp_r == 32'd0));
`ifdef MULTICYCLE_ALU_OVERFLOW_EN
        check({tag, ".ovf"}, 32'(Overflow), 32'(ref_overflow(op, a, b)));
`endif
    endtask

    initial begin
        int edges;
        int seen_done;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rs;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        ALUOperation = 4'd0;
        A = '0;
        B = '0;
        shamt = '0;

        // reset state
        @(posedge clk);
        #1;
        start = 1'b1;
        ALUOperation = 4'd3;
        A = 32'd1;
        @(posedge clk);
        #1;
        check("reset.result", ALUResult, 32'd0);
        check("reset.zero", 32'(Zero), 32'd1);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        start = 1'b0;
        reset = 1'b0;

        // ADD 5+7, done exactly one cycle
        do_op("add", 4'd3, 32'd5, 32'd7, 5'd0);
        @(posedge clk);
        #1;
        check("add.done_once", 32'(done), 32'd0);
        check("add.busy_never", 32'(busy), 32'd0);
        check("add.hold", ALUResult, 32'd12);

        // back-to-back single-cycle ops
        do_op("sub_eq", 4'd4, 32'd9, 32'd9, 5'd0);
        do_op("nor_zero", 4'd2, 32'd0, 32'd0, 5'd0);
        do_op("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        do_op("or", 4'd1, 32'hF000_0000, 32'h0000_000F, 5'd0);
        do_op("invalid", 4'd9, 32'h1234_5678, 32'h1, 5'd0);
        do_op("srl0", 4'd6, 32'd0, 32'h0000_ABCD, 5'd0);
        do_op("sll0", 4'd5, 32'd0, 32'h8000_0001, 5'd0);
        do_op("add_ovf", 4'd3, 32'h7FFF_FFFF, 32'd1, 5'd0);
        do_op("sub_ovf", 4'd4, 32'h8000_0000, 32'd1, 5'd0);
        do_op("and_noovf", 4'd0, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0);

        // SLL 1<<4 with a start pulsed during busy
        ALUOperation = 4'd5;
        A = 32'd0;
        B = 32'd1;
        shamt = 5'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("sll4.busy", 32'(busy), 32'd1);
        ALUOperation = 4'd3;
        A = 32'd100;
        B = 32'd200;
        shamt = 5'd0;
        @(posedge clk);
        #1;
        check("sll4.busy_ignore", 32'(busy), 32'd1);
        check("sll4.no_done", 32'(done), 32'd0);
        start = 1'b0;
        wait_done(edges);
        check("sll4.latency", 32'(edges), 32'd3);
        check("sll4.result", ALUResult, 32'h0000_0010);
        check("sll4.zero", 32'(Zero), 32'd0);
        @(posedge clk);
        #1;
        check("sll4.done_once", 32'(done), 32'd0);
        check("sll4.hold", ALUResult, 32'h0000_0010);

        // SRL full-width shift, then immediate new start on the next edge
        do_op("srl31", 4'd6, 32'd0, 32'h8000_0000, 5'd31);
        do_op("after_shift", 4'd3, 32'd3, 32'd4, 5'd0);
        do_op("sll_out", 4'd5, 32'd0, 32'h0000_0001, 5'd31);
        do_op("srl_zero", 4'd6, 32'd0, 32'h0000_0001, 5'd1);

        // reset abort on the third shift edge
        ALUOperation = 4'd5;
        B = 32'h0000_0003;
        shamt = 5'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort.busy_before", 32'(busy), 32'd1);
        check("abort.hold_before", ALUResult, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort.result", ALUResult, 32'd0);
        check("abort.zero", 32'(Zero), 32'd1);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done++;
        end
        check("abort.no_late_done", 32'(seen_done), 32'd0);
        do_op("abort.add", 4'd3, 32'd1, 32'd1, 5'd0);

        // randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 9));
            ra  = $urandom;
            rb  = $urandom;
            rs  = 5'($urandom);
            if (($urandom & 3) == 0) rb = 32'd0;
            do_op("rand", rop, ra, rb, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
